img_bus_arb: RTL
================

// Module: img_bus_arb
// PURPOSE
//  Two-master arbiter for the single image-memory system bus (active-low cs_n, we, ack handshake).
//  m0 is the image-processing controller; m1 is the display/host reader.
//  Grants the slave bus round-robin per transaction, with optional lock so a master can chain
//  consecutive accesses (e.g. 3-row read + write-back). A timeout aborts stalled accesses.
// PARAMETERS
//  AW           20   address width
//  DW           8    data width
//  TIMEOUT_CYC  255  cycles cs_n may stay low without ack before abort; 0 = timeout disabled
//  TO_W         8    timeout counter width; must satisfy 2**TO_W > TIMEOUT_CYC
// PORTS
//  clk        in   1   bus clock
//  rst_n      in   1   asynchronous active-low reset
//  m0_cs_n    in   1   master 0 request (low = access pending); m0_we/addr/wdata alike for m0
//  m0_we      in   1   master 0 write enable
//  m0_addr    in   AW  master 0 address
//  m0_wdata   in   DW  master 0 write data
//  m0_lock    in   1   master 0 keep grant after current ack
//  m0_ack     out  1   master 0 access complete (1-cycle pulse)
//  m1_cs_n, m1_we, m1_addr, m1_wdata, m1_lock, m1_ack: same as m0, for master 1
//  m_rdata    out  DW  slave read data, broadcast to both masters (valid with mX_ack)
//  m_err      out  1   1-cycle pulse, coincident with the mX_ack of a timed-out access
//  gnt        out  2   one-hot current owner {m1,m0}; 2'b00 when idle
//  s_cs_n     out  1   slave chip select (active low)
//  s_we       out  1   slave write enable
//  s_addr     out  AW  slave address
//  s_wdata    out  DW  slave write data
//  s_rdata    in   DW  slave read data
//  s_ack      in   1   slave acknowledge
// BEHAVIOUR
//  Reset values: gnt=00, s_cs_n=1, s_we=0, s_addr=0, s_wdata=0, m0_ack=m1_ack=0, m_err=0.
//  Internal reset values: state=IDLE, last_owner=1 (m0 wins the first tie), timeout counter=0.
//  Reset assertion mid-access: immediate return to reset values; any in-flight access is dropped
//   and no ack is issued.
//  FSM states: IDLE, OWN0, OWN1. gnt is registered and reflects the state.
//  IDLE:
//   - s_cs_n=1.
//   - If exactly one mX_cs_n is low, go to OWNX at the next edge.
//   - If both are low, the master != last_owner wins.
//   - Grant latency: 1 cycle from request to s_cs_n low.
//  OWNX:
//   - Combinational forwarding: s_cs_n=mX_cs_n; s_we, s_addr, s_wdata from master X;
//     s_we is forced 0 while s_cs_n=1.
//   - mX_ack = s_ack & ~mX_cs_n, routed combinationally. The non-owner's ack is always 0.
//   - m_rdata = s_rdata combinationally in all states.
//  On ack in OWNX:
//   - last_owner <= X.
//   - If mX_lock=1, stay in OWNX; otherwise go to IDLE.
//   - The other master then gets the bus after >=1 idle cycle (fair alternation).
//  OWNX with mX_cs_n=1:
//   - If mX_lock=1, stay (bus held, s_cs_n=1).
//   - If mX_lock=0, go to IDLE (request withdrawn, no ack).
//  Lock rules:
//   - Lock is sampled only at ack or while cs_n is high.
//   - A master holding lock indefinitely starves the other; lock is the master's responsibility.
//  Timeout:
//   - The counter clears on entering OWNX and on every ack.
//   - It increments each cycle with s_cs_n=0 and s_ack=0.
//   - When it reaches TIMEOUT_CYC: pulse mX_ack=1 and m_err=1 for one cycle, force s_cs_n=1
//     that cycle, set last_owner<=X, go to IDLE regardless of lock.
//  s_ack while s_cs_n=1 (or in IDLE): ignored, no master ack.
//  s_ack and timeout in the same cycle: the ack wins, m_err=0.
// TESTING
//  1. m0 read alone: m0_cs_n low, slave acks 3 cycles after s_cs_n low, s_rdata=8'hA5
//     -> gnt=01 one cycle after the request; m0_ack pulses with m_rdata=A5; gnt=00 next.
//  2. Both request in the same cycle after reset -> m0 served first, then m1 (gnt 01,00,10).
//     Repeated tie -> strict alternation m0,m1,m0,m1.
//  3. m0_lock=1 across 3 reads + 1 write while m1 requests
//     -> all 4 m0 accesses are served with no m1 grant; m1 is granted after m0 drops lock
//        at the 4th ack.
//  4. Slave never acks, TIMEOUT_CYC=4 -> after 4 low cycles: m0_ack=1 and m_err=1 for 1 cycle,
//     s_cs_n=1, state IDLE; a following m1 request is granted.
//  5. s_ack on the same cycle the count hits TIMEOUT -> normal ack, m_err=0.
//     Stray s_ack in IDLE -> no mX_ack.
//  6. rst_n low mid-access with s_cs_n=0 -> s_cs_n=1 and gnt=00 immediately, no ack.
//     After release, a tie goes to m0.

Source files
------------

// File: rtl/img_bus_arb.sv
// Two-master round-robin arbiter for the image-memory system bus. The owner's
// request is forwarded combinationally; an optional lock chains accesses and a
// timeout aborts accesses the slave never acknowledges.
module img_bus_arb #(
   parameter int AW          = 20,
   parameter int DW          = 8,
   parameter int TIMEOUT_CYC = 255,
   parameter int TO_W        = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_cs_n,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic          m0_lock,
   output logic          m0_ack,
   input  logic          m1_cs_n,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   input  logic          m1_lock,
   output logic          m1_ack,
   output logic [DW-1:0] m_rdata,
   output logic          m_err,
   output logic [1:0]    gnt,
   output logic          s_cs_n,
   output logic          s_we,
   output logic [AW-1:0] s_addr,
   output logic [DW-1:0] s_wdata,
   input  logic [DW-1:0] s_rdata,
   input  logic          s_ack
);

   typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;

   localparam logic            TO_EN  = (TIMEOUT_CYC != 0);
   localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC);

   state_t          state;
   logic            last_owner;
   logic [TO_W-1:0] to_cnt;

   logic own0, own1, sel_cs_n, sel_lock, active, acked, to_hit, done;

   assign own0     = (state == OWN0);
   assign own1     = (state == OWN1);
   assign sel_cs_n = own0 ? m0_cs_n : (own1 ? m1_cs_n : 1'b1);
   assign sel_lock = own0 ? m0_lock : (own1 ? m1_lock : 1'b0);
   assign active   = ~sel_cs_n;
   assign acked    = active & s_ack;
   // A real ack in the limit cycle beats the abort.
   assign to_hit   = TO_EN & active & ~s_ack & (to_cnt == TO_LIM);
   assign done     = acked | to_hit;

   assign s_cs_n  = ~active | to_hit;
   assign s_we    = ~s_cs_n & (own0 ? m0_we : m1_we);
   assign s_addr  = own0 ? m0_addr  : (own1 ? m1_addr  : '0);
   assign s_wdata = own0 ? m0_wdata : (own1 ? m1_wdata : '0);
   assign m0_ack  = own0 & done;
   assign m1_ack  = own1 & done;
   assign m_err   = to_hit;
   assign m_rdata = s_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         gnt        <= 2'b00;
         last_owner <= 1'b1;
         to_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               to_cnt <= '0;
               // On a tie the master that did not finish last wins.
               if (!m0_cs_n && (m1_cs_n || last_owner)) begin
                  state <= OWN0;
                  gnt   <= 2'b01;
               end else if (!m1_cs_n) begin
                  state <= OWN1;
                  gnt   <= 2'b10;
               end
            end
            default: begin
               if (done) begin
                  last_owner <= own1;
                  to_cnt     <= '0;
               end else if (active && TO_EN) begin
                  to_cnt <= to_cnt + 1'b1;
               end
               // Lock only matters at ack or while the owner is not requesting.
               if (to_hit || ((acked || sel_cs_n) && !sel_lock)) begin
                  state <= IDLE;
                  gnt   <= 2'b00;
               end
            end
         endcase
      end
   end

endmodule
